// File: rtl/demultiplexer_5ch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | demultiplexer_5ch_pkg                                                 |
// | Channel codes, slot state encoding and select helper for the demux.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package demultiplexer_5ch_pkg;

  localparam int NUM_CH = 5;

  localparam logic [2:0] CH_A = 3'd0;
  localparam logic [2:0] CH_B = 3'd1;
  localparam logic [2:0] CH_C = 3'd2;
  localparam logic [2:0] CH_D = 3'd3;
  localparam logic [2:0] CH_E = 3'd4;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Codes above CH_E name no slot; such words are dropped and counted.
  function automatic logic sel_is_valid(input logic [2:0] sel);
    return (sel <= CH_E);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demultiplexer_5ch_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | demultiplexer_5ch_if                                                  |
// | Input word handshake, five output slot handshakes and error status.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface demultiplexer_5ch_if #(
  parameter int word_size = 8,
  parameter int cnt_width = 8
);

  logic [word_size-1:0] data_in;
  logic [2:0]           sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [word_size-1:0] data_a;
  logic [word_size-1:0] data_b;
  logic [word_size-1:0] data_c;
  logic [word_size-1:0] data_d;
  logic [word_size-1:0] data_e;
  logic [4:0]           out_valid;
  logic [4:0]           out_ready;
  logic                 clr_err;
  logic                 sel_err;
  logic [cnt_width-1:0] drop_cnt;

  modport master (
    output data_in, sel, in_valid, out_ready, clr_err,
    input  in_ready, data_a, data_b, data_c, data_d, data_e,
           out_valid, sel_err, drop_cnt
  );

  modport slave (
    input  data_in, sel, in_valid, out_ready, clr_err,
    output in_ready, data_a, data_b, data_c, data_d, data_e,
           out_valid, sel_err, drop_cnt
  );

endinterface
`default_nettype wire

// File: rtl/demultiplexer_5ch_ch_slot.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | demux_ch_slot                                                         |
// | One-deep output slot with valid/ready drain; a load beats a drain.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module demux_ch_slot
  import demultiplexer_5ch_pkg::*;
#(
  parameter int word_size = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [word_size-1:0] load_data,
  input  logic                 drain_ready,
  output logic [word_size-1:0] data,
  output logic                 valid
);

  slot_state_t          r_state;
  slot_state_t          w_state_nxt;
  logic [word_size-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (load) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (!load && drain_ready) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  // Data is kept after a drain; only a load or reset changes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= load_data;
    end
  end

  assign data  = r_data;
  assign valid = (r_state == SLOT_FULL);

endmodule
`default_nettype wire

// File: rtl/demultiplexer_5ch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | demultiplexer_5ch                                                     |
// | Registered 1-to-5 word distributor with drop tracking for bad sel.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module demultiplexer_5ch
  import demultiplexer_5ch_pkg::*;
#(
  parameter int word_size = 8,
  parameter int cnt_width = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  demultiplexer_5ch_if.slave  bus
);

  localparam logic [cnt_width-1:0] c_cnt_max = '1;

  logic [NUM_CH-1:0]    w_load;
  logic [NUM_CH-1:0]    w_valid;
  logic [NUM_CH-1:0]    w_ch_ready;
  logic [word_size-1:0] w_data [NUM_CH];
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_drop;
  logic                 r_sel_err;
  logic [cnt_width-1:0] r_drop_cnt;

  assign w_ch_ready = ~w_valid | bus.out_ready;

  // Ready depends only on the addressed slot; invalid codes are always taken.
  always_comb begin
    w_in_ready = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.sel == 3'(k)) w_in_ready = w_ch_ready[k];
    end
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_drop   = w_accept && !sel_is_valid(bus.sel);

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_load[k] = w_accept && (bus.sel == 3'(k));

      demux_ch_slot #(
        .word_size (word_size)
      ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (w_load[k]),
        .load_data   (bus.data_in),
        .drain_ready (bus.out_ready[k]),
        .data        (w_data[k]),
        .valid       (w_valid[k])
      );
    end
  endgenerate

  // A drop in the same cycle as a clear wins, leaving a count of one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_sel_err <= 1'b1;
      if (bus.clr_err) begin
        r_drop_cnt <= cnt_width'(1);
      end else if (r_drop_cnt != c_cnt_max) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end else if (bus.clr_err) begin
      r_sel_err  <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.data_a    = w_data[CH_A];
  assign bus.data_b    = w_data[CH_B];
  assign bus.data_c    = w_data[CH_C];
  assign bus.data_d    = w_data[CH_D];
  assign bus.data_e    = w_data[CH_E];
  assign bus.sel_err   = r_sel_err;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demultiplexer_5ch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_demultiplexer_5ch                                                  |
// | Scenario tasks plus a per-channel queue model of the distributor.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_demultiplexer_5ch;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [7:0] sb_q [5][$];
  logic [7:0] last_d [5];
  logic       m_err;
  logic [7:0] m_cnt;

  demultiplexer_5ch_if #(.word_size(8), .cnt_width(8)) bus ();

  demultiplexer_5ch #(
    .word_size (8),
    .cnt_width (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ch_data(input int k);
    case (k)
      0:       return bus.data_a;
      1:       return bus.data_b;
      2:       return bus.data_c;
      3:       return bus.data_d;
      default: return bus.data_e;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 5; k++) begin
      sb_q[k].delete();
      last_d[k] = 8'h00;
    end
    m_err = 1'b0;
    m_cnt = 8'h00;
  endtask

  // Compare the DUT against the model at negedge, then advance both one clock.
  task automatic step();
    logic [4:0] exp_valid;
    logic [7:0] exp_d;
    logic       exp_ready;
    logic       acc;
    int         s;
    @(negedge clk);
    for (int k = 0; k < 5; k++) exp_valid[k] = (sb_q[k].size() != 0);
    n_checks++;
    if (bus.out_valid !== exp_valid) begin
      n_errors++;
      $display("FAIL out_valid: got %b expected %b", bus.out_valid, exp_valid);
    end
    for (int k = 0; k < 5; k++) begin
      exp_d = exp_valid[k] ? sb_q[k][0] : last_d[k];
      n_checks++;
      if (ch_data(k) !== exp_d) begin
        n_errors++;
        $display("FAIL data ch%0d: got %h expected %h", k, ch_data(k), exp_d);
      end
    end
    s = int'(bus.sel);
    exp_ready = (s >= 5) ? 1'b1 : (!exp_valid[s] || bus.out_ready[s]);
    n_checks++;
    if (bus.in_ready !== exp_ready) begin
      n_errors++;
      $display("FAIL in_ready sel=%0d: got %b expected %b", s, bus.in_ready, exp_ready);
    end
    n_checks++;
    if (bus.sel_err !== m_err || bus.drop_cnt !== m_cnt) begin
      n_errors++;
      $display("FAIL err/cnt: got %b/%0d expected %b/%0d", bus.sel_err, bus.drop_cnt, m_err, m_cnt);
    end
    acc = bus.in_valid && exp_ready;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (exp_valid[k] && bus.out_ready[k]) void'(sb_q[k].pop_front());
      end
      if (acc && s < 5) begin
        sb_q[s].push_back(bus.data_in);
        last_d[s] = bus.data_in;
      end
      if (acc && s >= 5) begin
        m_err = 1'b1;
        m_cnt = bus.clr_err ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
      end else if (bus.clr_err) begin
        m_err = 1'b0;
        m_cnt = 8'h00;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    n_checks++;
    if (bus.out_valid !== 5'b0 || bus.sel_err !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset state: got %b/%b/%0d expected 00000/0/0", bus.out_valid, bus.sel_err, bus.drop_cnt);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    bus.sel = 3'd2; bus.data_in = 8'hA5; bus.in_valid = 1'b1; bus.out_ready = 5'b0;
    step();
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 5'b00100 || bus.data_c !== 8'hA5) begin
      n_errors++;
      $display("FAIL basic load: got %b/%h expected 00100/a5", bus.out_valid, bus.data_c);
    end
    n_checks++;
    if ({bus.data_a, bus.data_b, bus.data_d, bus.data_e} !== 32'h0) begin
      n_errors++;
      $display("FAIL basic others: got %h expected 0", {bus.data_a, bus.data_b, bus.data_d, bus.data_e});
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL basic ready sel2: got %b expected 0", bus.in_ready);
    end
    bus.sel = 3'd0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL basic ready sel0: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    bus.sel = 3'd2; bus.data_in = 8'h3C; bus.in_valid = 1'b1; bus.out_ready = 5'b00100;
    step();
    n_checks++;
    if (bus.out_valid[2] !== 1'b1 || bus.data_c !== 8'h3C) begin
      n_errors++;
      $display("FAIL replace: got %b/%h expected 1/3c", bus.out_valid[2], bus.data_c);
    end
    for (int i = 0; i < 4; i++) begin
      bus.data_in = 8'h40 + 8'(i);
      step();
      n_checks++;
      if (bus.data_c !== 8'h40 + 8'(i) || bus.out_valid[2] !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b word %0d: got %h expected %h", i, bus.data_c, 8'h40 + 8'(i));
      end
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 5'b0;
  endtask

  task automatic test_backpressure();
    bus.sel = 3'd0; bus.data_in = 8'h77; bus.in_valid = 1'b1; bus.out_ready = 5'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.sel = 3'd4; bus.data_in = 8'h11;
      end else begin
        bus.sel = 3'd0; bus.data_in = 8'h88;
      end
      #1;
      n_checks++;
      if ((bus.sel == 3'd0 && bus.in_ready !== 1'b0) || bus.data_a !== 8'h77) begin
        n_errors++;
        $display("FAIL backpressure cyc %0d: got rdy=%b a=%h expected rdy=0 a=77", i, bus.in_ready, bus.data_a);
      end
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 5'b10001 || bus.data_e !== 8'h11) begin
      n_errors++;
      $display("FAIL bypass e: got %b/%h expected 10001/11", bus.out_valid, bus.data_e);
    end
    bus.out_ready = 5'b11111;
    step();
    bus.out_ready = 5'b0;
  endtask

  task automatic test_drop();
    bus.sel = 3'd6; bus.data_in = 8'hEE; bus.in_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL drop ready: got %b expected 1", bus.in_ready);
    end
    repeat (3) step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.sel_err !== 1'b1 || bus.drop_cnt !== 8'd3 || bus.out_valid !== 5'b0) begin
      n_errors++;
      $display("FAIL drop x3: got %b/%0d/%b expected 1/3/00000", bus.sel_err, bus.drop_cnt, bus.out_valid);
    end
    bus.clr_err = 1'b1; bus.sel = 3'd7; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.sel_err !== 1'b1 || bus.drop_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL clr+drop: got %b/%0d expected 1/1", bus.sel_err, bus.drop_cnt);
    end
    step();
    bus.clr_err = 1'b0;
    n_checks++;
    if (bus.sel_err !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL clr: got %b/%0d expected 0/0", bus.sel_err, bus.drop_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      bus.sel       = 3'($urandom_range(0, 5));
      bus.data_in   = 8'($urandom);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 5'($urandom);
      bus.clr_err   = ($urandom_range(0, 15) == 0);
      step();
    end
    bus.in_valid = 1'b0; bus.clr_err = 1'b0; bus.out_ready = 5'b11111;
    step();
    bus.out_ready = 5'b0;
  endtask

  task automatic test_saturate();
    bus.sel = 3'd5; bus.in_valid = 1'b1;
    repeat (300) step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.drop_cnt !== 8'd255 || bus.sel_err !== 1'b1) begin
      n_errors++;
      $display("FAIL saturate: got %0d/%b expected 255/1", bus.drop_cnt, bus.sel_err);
    end
  endtask

  task automatic test_reset_midop();
    bus.out_ready = 5'b0; bus.in_valid = 1'b1;
    bus.sel = 3'd0; bus.data_in = 8'h5A;
    step();
    bus.sel = 3'd3; bus.data_in = 8'hD3;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 5'b01001) begin
      n_errors++;
      $display("FAIL pre-reset fill: got %b expected 01001", bus.out_valid);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.sel = 3'd0;
    #1;
    n_checks++;
    if (bus.out_valid !== 5'b0 || {bus.data_a, bus.data_b, bus.data_c, bus.data_d, bus.data_e} !== 40'h0) begin
      n_errors++;
      $display("FAIL midop reset slots: got %b/%h expected 00000/0", bus.out_valid,
               {bus.data_a, bus.data_b, bus.data_c, bus.data_d, bus.data_e});
    end
    n_checks++;
    if (bus.sel_err !== 1'b0 || bus.drop_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midop reset status: got %b/%0d/%b expected 0/0/1", bus.sel_err, bus.drop_cnt, bus.in_ready);
    end
    step();
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.data_in   = 8'h00;
    bus.sel       = 3'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 5'b0;
    bus.clr_err   = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_random();
    test_saturate();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
